reg_decode_scoreboard: RTL and testbench

- Parametrised successor to the register-file address decoder.
- Decodes the writeback destination into a registered one-hot write-enable vector for the register file.
- Tracks pending writes per register in a busy scoreboard and flags RAW hazards on two source operands.
- Sits between the issue stage and register-file write port; the issue stage stalls on issue_ready low or any hazard.

---
 rtl/reg_decode_scoreboard.sv | 84 ++++++++
 tb/tb_reg_decode_scoreboard.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reg_decode_scoreboard.sv
// Register-file writeback decoder with a per-register busy scoreboard.
// Produces a registered one-hot write enable and flags RAW/WAW hazards for the issue stage.
module reg_decode_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [ADDR_W:0]     busy_count,
  output logic                err,
  input  logic                err_clr
);

  if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_params
    $error("reg_decode_scoreboard: NUM_REGS must equal 2**ADDR_W");
  end

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W:0]     busy_count_q, busy_count_d;
  logic                err_q, err_d;

  function automatic logic is_exempt(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A same-cycle writeback to a source is forwarded downstream, so it is not a hazard.
  always_comb begin
    issue_ready = is_exempt(issue_rd) || !busy_q[issue_rd] ||
                  (wb_valid && (wb_rd == issue_rd));
    rs1_busy    = !is_exempt(rs1) && busy_q[rs1] && !(wb_valid && (wb_rd == rs1));
    rs2_busy    = !is_exempt(rs2) && busy_q[rs2] && !(wb_valid && (wb_rd == rs2));
  end

  // Clear before set so a coinciding issue to the same register keeps it busy.
  always_comb begin
    busy_d  = busy_q;
    wr_en_d = '0;
    err_d   = err_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
      if (!is_exempt(wb_rd)) wr_en_d[wb_rd] = 1'b1;
    end
    if (issue_valid && issue_ready && !is_exempt(issue_rd)) busy_d[issue_rd] = 1'b1;
    if (err_clr) err_d = 1'b0;
    if (wb_valid && !busy_q[wb_rd] && !is_exempt(wb_rd)) err_d = 1'b1;
    busy_count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= '0;
      wr_en_q      <= '0;
      busy_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      busy_count_q <= busy_count_d;
      err_q        <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign busy_vec   = busy_q;
  assign busy_count = busy_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_reg_decode_scoreboard.sv
// Directed bench for reg_decode_scoreboard: a ZERO_REG=1 instance and a ZERO_REG=0
// instance share all inputs; the second is only examined in the register-0 steps.
module tb_reg_decode_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1, rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        err_clr;

  logic        issue_ready, rs1_busy, rs2_busy, err;
  logic [31:0] wr_en, busy_vec;
  logic [5:0]  busy_count;

  logic        z_issue_ready, z_rs1_busy, z_rs2_busy, z_err;
  logic [31:0] z_wr_en, z_busy_vec;
  logic [5:0]  z_busy_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reg_decode_scoreboard #(.ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wr_en(wr_en), .busy_vec(busy_vec), .busy_count(busy_count),
    .err(err), .err_clr(err_clr)
  );

  reg_decode_scoreboard #(.ADDR_W(5), .NUM_REGS(32), .ZERO_REG(0)) dut_z0 (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(z_issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(z_rs1_busy), .rs2_busy(z_rs2_busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wr_en(z_wr_en), .busy_vec(z_busy_vec), .busy_count(z_busy_count),
    .err(z_err), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    wb_valid = 1'b0; wb_rd = '0; err_clr = 1'b0;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_busy_vec"}, busy_vec, 0);
    chk({tag, "_busy_count"}, busy_count, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;

    // 1: reset with random inputs, then idle
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'($urandom_range(0, 1)); issue_rd = 5'($urandom_range(0, 31));
      wb_valid = 1'($urandom_range(0, 1));    wb_rd = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));        rs2 = 5'($urandom_range(0, 31));
      step();
    end
    chk_clear("t1_in_reset");
    idle_inputs();
    reset_n = 1'b1;
    repeat (5) step();
    chk_clear("t1_idle");

    // 2: issue rd=5, RAW hazard, WAW stall, same-cycle writeback resolves it
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1 chk("t2_ready_first", issue_ready, 1);
    step();
    issue_valid = 1'b0; rs1 = 5'd5; rs2 = 5'd6;
    #1;
    chk("t2_busy_vec", busy_vec, 64'h20);
    chk("t2_busy_count", busy_count, 1);
    chk("t2_rs1_busy", rs1_busy, 1);
    chk("t2_rs2_busy", rs2_busy, 0);
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1 chk("t2_ready_waw", issue_ready, 0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    chk("t2_ready_wb", issue_ready, 1);
    chk("t2_rs1_bypass", rs1_busy, 0);
    step();
    idle_inputs();
    #1;
    chk("t2_wr_en", wr_en, 64'h20);
    chk("t2_busy_set_wins", busy_vec, 64'h20);
    chk("t2_count_after", busy_count, 1);
    chk("t2_err", err, 0);
    step();
    chk("t2_wr_en_drop", wr_en, 0);

    // 3: issue every register, then sweep writebacks back-to-back
    for (int i = 0; i < 32; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      step();
    end
    idle_inputs();
    #1;
    chk("t3_busy_all", busy_vec, 64'hFFFF_FFFE);
    chk("t3_count_all", busy_count, 31);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp_we;
      wb_valid = 1'b1; wb_rd = 5'(i);
      step();
      exp_we = (i == 0) ? 32'h0 : (32'h1 << i);
      chk($sformatf("t3_wr_en_%0d", i), wr_en, exp_we);
    end
    idle_inputs();
    step();
    chk_clear("t3_end");

    // 4: erroneous writeback, err_clr against a new error, err_clr alone
    wb_valid = 1'b1; wb_rd = 5'd7;
    step();
    chk("t4_err_set", err, 1);
    chk("t4_wr_en", wr_en, 64'h80);
    wb_rd = 5'd8; err_clr = 1'b1;
    step();
    chk("t4_set_wins", err, 1);
    chk("t4_wr_en8", wr_en, 64'h100);
    wb_valid = 1'b0;
    step();
    chk("t4_cleared", err, 0);
    idle_inputs();

    // 5: register 0 exempt vs ordinary
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    #1;
    chk("t5_ready", issue_ready, 1);
    chk("t5_rs1_zero", rs1_busy, 0);
    chk("t5_z0_ready", z_issue_ready, 1);
    step();
    issue_valid = 1'b0;
    #1;
    chk("t5_busy_vec", busy_vec, 0);
    chk("t5_busy_count", busy_count, 0);
    chk("t5_rs1_after", rs1_busy, 0);
    chk("t5_z0_busy_vec", z_busy_vec, 64'h1);
    chk("t5_z0_count", z_busy_count, 1);
    chk("t5_z0_rs1", z_rs1_busy, 1);
    wb_valid = 1'b1; wb_rd = 5'd0;
    step();
    chk("t5_wr_en_zero", wr_en, 0);
    chk("t5_z0_wr_en", z_wr_en, 64'h1);
    chk("t5_err", err, 0);
    chk("t5_z0_err", z_err, 0);
    idle_inputs();

    // 6: asynchronous reset mid-cycle with pending state
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    chk("t6_busy3", busy_vec, 64'h8);
    issue_rd = 5'd9; wb_valid = 1'b1; wb_rd = 5'd3;
    step();
    chk("t6_busy9", busy_vec, 64'h200);
    chk("t6_count", busy_count, 1);
    chk("t6_wr_en3", wr_en, 64'h8);
    issue_valid = 1'b0; wb_rd = 5'd9;
    #2 reset_n = 1'b0;
    #1;
    chk_clear("t6_async");
    step();
    reset_n = 1'b1;
    idle_inputs();
    step();
    chk_clear("t6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
